// File: rtl/serial_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_frame_tx
//  Description : Parallel-to-serial frame transmitter. Accepts a WIDTH-bit
//                word over valid/ready and sends start bit, WIDTH data bits
//                and a stop bit, each held for CLKS_PER_BIT clocks. s_frame
//                qualifies the data bits for the downstream shift register.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int MSB_FIRST    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             s_out,
    output logic             s_frame,
    output logic             done
);

    // Timer is at least one bit wide so CLKS_PER_BIT=1 still has a legal vector.
    localparam int c_TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_CW = $clog2(WIDTH);

    localparam logic [c_TW-1:0] c_TMAX = c_TW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_CMAX = c_CW'(WIDTH - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    logic [1:0]       r_state;
    logic [c_TW-1:0]  r_timer;
    logic [c_CW-1:0]  r_count;
    logic [WIDTH-1:0] r_shift;
    logic             r_in_ready;
    logic             r_s_out;
    logic             r_s_frame;
    logic             r_done;

    logic [1:0]       w_state_nxt;
    logic [c_TW-1:0]  w_timer_nxt;
    logic [c_CW-1:0]  w_count_nxt;
    logic [WIDTH-1:0] w_shift_nxt;
    logic             w_bit_end;
    logic             w_bit_nxt;

    assign w_bit_end = (r_timer == c_TMAX);

    // Bit that the line carries once the holding register takes its next value.
    assign w_bit_nxt = (MSB_FIRST != 0) ? w_shift_nxt[WIDTH-1] : w_shift_nxt[0];

    // Next-state logic: bit timing, data bit counting and holding-register shifts.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = '0;
        w_count_nxt = r_count;
        w_shift_nxt = r_shift;
        if (r_state != c_ST_IDLE) begin
            w_timer_nxt = w_bit_end ? '0 : r_timer + 1'b1;
        end
        case (r_state)
            c_ST_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_shift_nxt = in_data;
                    w_state_nxt = c_ST_START;
                end
            end
            c_ST_START: begin
                if (w_bit_end) begin
                    w_state_nxt = c_ST_DATA;
                    w_count_nxt = '0;
                end
            end
            c_ST_DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = (MSB_FIRST != 0) ? {r_shift[WIDTH-2:0], 1'b0}
                                                   : {1'b0, r_shift[WIDTH-1:1]};
                    if (r_count == c_CMAX) begin
                        w_state_nxt = c_ST_STOP;
                    end else begin
                        w_count_nxt = r_count + 1'b1;
                    end
                end
            end
            c_ST_STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; outputs reflect the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_timer    <= '0;
            r_count    <= '0;
            r_shift    <= '0;
            r_in_ready <= 1'b1;
            r_s_out    <= 1'b0;
            r_s_frame  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_count    <= w_count_nxt;
            r_shift    <= w_shift_nxt;
            r_in_ready <= (w_state_nxt == c_ST_IDLE);
            r_s_frame  <= (w_state_nxt == c_ST_DATA);
            r_s_out    <= (w_state_nxt == c_ST_START) ||
                          ((w_state_nxt == c_ST_DATA) && w_bit_nxt);
            r_done     <= (r_state == c_ST_STOP) && (w_state_nxt == c_ST_IDLE);
        end
    end

    assign in_ready = r_in_ready;
    assign s_out    = r_s_out;
    assign s_frame  = r_s_frame;
    assign done     = r_done;

endmodule
`default_nettype wire
